// File: rtl/incubator_ctrl_param_if.sv
// incubator_ctrl_param_if: sensor/command inputs and actuator/status outputs of the incubator controller
interface incubator_ctrl_param_if #(
  parameter int SW    = 8,
  parameter int FAN_W = 4
);
  logic signed [SW-1:0] sensor;
  logic                 sensor_valid;
  logic                 alarm_clr;
  logic                 heater;
  logic                 cooler;
  logic [FAN_W-1:0]     fan;
  logic [2:0]           state_o;
  logic                 alarm;
  modport master (
    output sensor, sensor_valid, alarm_clr,
    input  heater, cooler, fan, state_o, alarm
  );
  modport slave (
    input  sensor, sensor_valid, alarm_clr,
    output heater, cooler, fan, state_o, alarm
  );
endinterface

// File: rtl/incubator_ctrl_param.sv
// incubator_ctrl_param: parametrised hysteresis heater/cooler/fan FSM with dwell debounce, sticky alarm; FAN_RAMP_EN enables fan ramping
module incubator_ctrl_param #(
  parameter int SW        = 8,
  parameter int FAN_W     = 4,
  parameter int HEAT_ON   = 15,
  parameter int HEAT_OFF  = 30,
  parameter int COOL_ON   = 35,
  parameter int COOL_OFF  = 25,
  parameter int FAN1_ON   = 38,
  parameter int FAN1_OFF  = 33,
  parameter int FAN2_ON   = 40,
  parameter int FAN2_OFF  = 35,
  parameter int FAN3_ON   = 45,
  parameter int FAN3_OFF  = 40,
  parameter int FAN_L1    = 4,
  parameter int FAN_L2    = 6,
  parameter int FAN_L3    = 8,
  parameter int DWELL     = 3,
  parameter int ALARM_HI  = 50,
  parameter int ALARM_LO  = 5,
  parameter int ALARM_CYC = 4,
  parameter int RAMP_DIV  = 2
) (
  input logic                   clk,
  input logic                   rst,
  incubator_ctrl_param_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, HEAT, COOL, FAN1, FAN2, FAN3, BAD6, NONE} state_t;
  localparam int DW = $clog2(DWELL + 1);
  localparam int AW = $clog2(ALARM_CYC + 1);
  localparam logic signed [SW-1:0] T_HEAT_ON  = SW'(HEAT_ON);
  localparam logic signed [SW-1:0] T_HEAT_OFF = SW'(HEAT_OFF);
  localparam logic signed [SW-1:0] T_COOL_ON  = SW'(COOL_ON);
  localparam logic signed [SW-1:0] T_COOL_OFF = SW'(COOL_OFF);
  localparam logic signed [SW-1:0] T_FAN1_ON  = SW'(FAN1_ON);
  localparam logic signed [SW-1:0] T_FAN1_OFF = SW'(FAN1_OFF);
  localparam logic signed [SW-1:0] T_FAN2_ON  = SW'(FAN2_ON);
  localparam logic signed [SW-1:0] T_FAN2_OFF = SW'(FAN2_OFF);
  localparam logic signed [SW-1:0] T_FAN3_ON  = SW'(FAN3_ON);
  localparam logic signed [SW-1:0] T_FAN3_OFF = SW'(FAN3_OFF);
  localparam logic signed [SW-1:0] T_ALARM_HI = SW'(ALARM_HI);
  localparam logic signed [SW-1:0] T_ALARM_LO = SW'(ALARM_LO);
  if (DWELL < 1 || ALARM_CYC < 1 || RAMP_DIV < 1) begin : g_bad_cfg
    $error("incubator_ctrl_param: DWELL, ALARM_CYC and RAMP_DIV must be >= 1");
  end
  state_t               state_q, state_d, cand, prev_q, prev_d;
  logic [DW-1:0]        dcnt_q, dcnt_d, dcnt_n;
  logic [AW-1:0]        acnt_q, acnt_d, acnt_n;
  logic                 alarm_q, alarm_d, heater_q, cooler_q, oor;
  logic [FAN_W-1:0]     fan_q, tgt;
  logic signed [SW-1:0] s;
  assign s = bus.sensor;
  // where the current sample pushes the FSM; NONE while it sits inside the hysteresis band
  always_comb begin
    cand = NONE;
    case (state_q)
      IDLE: cand = (s < T_HEAT_ON) ? HEAT : (s > T_COOL_ON) ? COOL : NONE;
      HEAT: cand = (s > T_HEAT_OFF) ? IDLE : NONE;
      COOL: cand = (s < T_COOL_OFF) ? IDLE : (s > T_FAN1_ON) ? FAN1 : NONE;
      FAN1: cand = (s > T_FAN2_ON) ? FAN2 : (s < T_FAN1_OFF) ? COOL : NONE;
      FAN2: cand = (s > T_FAN3_ON) ? FAN3 : (s < T_FAN2_OFF) ? FAN1 : NONE;
      FAN3: cand = (s < T_FAN3_OFF) ? FAN2 : NONE;
      default: cand = NONE;
    endcase
  end
  // a move is taken only after DWELL consecutive valid samples agree on the same target
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    prev_d  = prev_q;
    dcnt_n  = (cand == prev_q) ? ((dcnt_q == '1) ? dcnt_q : dcnt_q + 1'b1) : DW'(1);
    if (state_q == BAD6 || state_q == NONE) begin
      state_d = IDLE;
      dcnt_d  = '0;
      prev_d  = NONE;
    end else if (bus.sensor_valid) begin
      if (cand == NONE) begin
        dcnt_d = '0;
        prev_d = NONE;
      end else if (dcnt_n >= DW'(DWELL)) begin
        state_d = cand;
        dcnt_d  = '0;
        prev_d  = NONE;
      end else begin
        dcnt_d = dcnt_n;
        prev_d = cand;
      end
    end
  end
  // alarm counts consecutive valid out-of-range samples; a clear pulse beats a coincident raise
  always_comb begin
    oor     = (s > T_ALARM_HI) || (s < T_ALARM_LO);
    acnt_n  = !bus.sensor_valid ? acnt_q : !oor ? '0 : (acnt_q >= AW'(ALARM_CYC)) ? acnt_q : acnt_q + 1'b1;
    acnt_d  = bus.alarm_clr ? '0 : acnt_n;
    alarm_d = bus.alarm_clr ? 1'b0 : (alarm_q || acnt_n >= AW'(ALARM_CYC));
  end
  assign tgt = (state_d == FAN1) ? FAN_W'(FAN_L1) :
               (state_d == FAN2) ? FAN_W'(FAN_L2) :
               (state_d == FAN3) ? FAN_W'(FAN_L3) : '0;
  // state, counters and heater/cooler/alarm outputs, decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= NONE;
      dcnt_q   <= '0;
      acnt_q   <= '0;
      alarm_q  <= 1'b0;
      heater_q <= 1'b0;
      cooler_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      dcnt_q   <= dcnt_d;
      acnt_q   <= acnt_d;
      alarm_q  <= alarm_d;
      heater_q <= (state_d == HEAT);
      cooler_q <= (state_d == COOL) || (state_d == FAN1) || (state_d == FAN2) || (state_d == FAN3);
    end
  end
`ifdef FAN_RAMP_EN
  localparam int RW = $clog2(RAMP_DIV + 1);
  logic [RW-1:0] rdiv_q;
  // fan creeps one level every RAMP_DIV cycles toward the level of the state in force
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fan_q  <= '0;
      rdiv_q <= '0;
    end else if (fan_q == tgt) begin
      rdiv_q <= '0;
    end else if (rdiv_q >= RW'(RAMP_DIV - 1)) begin
      rdiv_q <= '0;
      fan_q  <= (fan_q < tgt) ? fan_q + 1'b1 : fan_q - 1'b1;
    end else begin
      rdiv_q <= rdiv_q + 1'b1;
    end
  end
`else
  // fan jumps straight to the level of the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fan_q <= '0;
    else fan_q <= tgt;
  end
`endif
  assign bus.heater  = heater_q;
  assign bus.cooler  = cooler_q;
  assign bus.fan     = fan_q;
  assign bus.state_o = state_q;
  assign bus.alarm   = alarm_q;
endmodule
